// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - fetches instruction words, runs NOP/JUMP/REPEAT/HALT locally
// and issues datapath opcodes downstream over valid/ready, one instruction in flight.
module instruction_sequencer #(
  parameter int INST_ADDR_WIDTH = 12,
  parameter int REPEAT_WIDTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [INST_ADDR_WIDTH-1:0] start_addr,
  output logic                       imem_rd_en,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]                imem_rdata,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_data,
  output logic                       busy,
  output logic                       halted,
  output logic                       illegal_op
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_HALT   = 4'd9;
  localparam logic [3:0] OP_REPEAT = 4'd10;
  localparam logic [3:0] OP_JUMP   = 4'd11;

  state_t                     state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]                ir_q, ir_d;
  logic [REPEAT_WIDTH-1:0]    rep_cnt_q, rep_cnt_d;
  logic [REPEAT_WIDTH-1:0]    issue_cnt_q, issue_cnt_d;
  logic                       arm_q, arm_d;
  logic                       rd_en_q, rd_en_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       halted_q, halted_d;
  logic                       illegal_q, illegal_d;

  logic [3:0]                 opcode;
  logic [INST_ADDR_WIDTH-1:0] pc_inc;
  logic [REPEAT_WIDTH-1:0]    rep_field;

  assign opcode    = imem_rdata[31:28];
  assign pc_inc    = pc_q + INST_ADDR_WIDTH'(1);
  assign rep_field = imem_rdata[REPEAT_WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    rep_cnt_d   = rep_cnt_q;
    issue_cnt_d = issue_cnt_q;
    arm_d       = arm_q;
    illegal_d   = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          pc_d    = start_addr;
          arm_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        // imem_rdata is classified directly: IR only captures it on this same edge
        ir_d = imem_rdata;
        if (opcode == OP_JUMP) begin
          pc_d    = imem_rdata[INST_ADDR_WIDTH-1:0];
          arm_d   = 1'b0;
          state_d = S_FETCH;
        end else if (opcode == OP_REPEAT) begin
          rep_cnt_d = (rep_field == '0) ? REPEAT_WIDTH'(1) : rep_field;
          arm_d     = 1'b1;
          pc_d      = pc_inc;
          state_d   = S_FETCH;
        end else if (opcode == OP_HALT) begin
          arm_d   = 1'b0;
          state_d = S_HALTED;
        end else if (opcode >= 4'd1 && opcode <= 4'd8) begin
          issue_cnt_d = arm_q ? rep_cnt_q : REPEAT_WIDTH'(1);
          arm_d       = 1'b0;
          state_d     = S_ISSUE;
        end else begin
          illegal_d = (opcode >= 4'd12);
          pc_d      = pc_inc;
          state_d   = S_FETCH;
        end
      end
      S_ISSUE: begin
        if (valid_q && inst_ready) begin
          if (issue_cnt_q == REPEAT_WIDTH'(1)) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end else begin
            issue_cnt_d = issue_cnt_q - REPEAT_WIDTH'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they align with the state they describe
    rd_en_d  = (state_d == S_FETCH);
    valid_d  = (state_d == S_ISSUE);
    busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_ISSUE);
    halted_d = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      rep_cnt_q   <= '0;
      issue_cnt_q <= '0;
      arm_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      rep_cnt_q   <= rep_cnt_d;
      issue_cnt_q <= issue_cnt_d;
      arm_q       <= arm_d;
      rd_en_q     <= rd_en_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
    end
  end

  assign imem_rd_en = rd_en_q;
  assign imem_addr  = pc_q;
  assign inst_valid = valid_q;
  assign inst_data  = ir_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - bench for instruction_sequencer: directed programs and
// random programs compared against an instruction-level interpreter of the sequencer.
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] start_addr = '0;
  logic        imem_rd_en;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic        busy;
  logic        halted;
  logic        illegal_op;

  instruction_sequencer #(.INST_ADDR_WIDTH(12), .REPEAT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .busy(busy), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] W_HALT = 32'h9000_0000;

  logic [31:0] mem [0:4095];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          start_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  // Observed activity of one program run
  logic [31:0] got_fetch[$];
  logic [31:0] got_issue[$];
  logic [31:0] exp_fetch[$];
  logic [31:0] exp_issue[$];
  bit          rpat[$];
  int          ill_cnt, exp_ill, stab_err;
  int          first_fetch_rel, first_valid_rel, halted_rel;
  bit          mon_en = 1'b0;
  bit          timed_out;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (imem_rd_en) begin
        got_fetch.push_back({20'd0, imem_addr});
        if (first_fetch_rel < 0) first_fetch_rel = cyc - start_cyc;
      end
      if (inst_valid && first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
      if (inst_valid && inst_ready) got_issue.push_back(inst_data);
      if (illegal_op) ill_cnt++;
      if (prev_stall && (!inst_valid || inst_data !== prev_data)) stab_err++;
      prev_stall = inst_valid && !inst_ready;
      prev_data  = inst_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = W_HALT;
  endtask

  // Instruction-level interpreter: what the sequencer should fetch and hand downstream
  task automatic model(input logic [11:0] a);
    int pc, rep;
    bit arm;
    logic [31:0] w;
    int op;
    exp_fetch.delete();
    exp_issue.delete();
    exp_ill = 0;
    pc = a; arm = 0; rep = 0;
    for (int step = 0; step < 2000; step++) begin
      exp_fetch.push_back(pc);
      w = mem[pc];
      op = w[31:28];
      if (op == 9) break;
      if (op == 11) begin
        pc = w[11:0]; arm = 0;
      end else if (op == 10) begin
        rep = (w[15:0] == 0) ? 1 : w[15:0]; arm = 1; pc = (pc + 1) % 4096;
      end else if (op >= 1 && op <= 8) begin
        for (int k = 0; k < (arm ? rep : 1); k++) exp_issue.push_back(w);
        arm = 0; pc = (pc + 1) % 4096;
      end else begin
        if (op >= 12) exp_ill++;
        pc = (pc + 1) % 4096;
      end
    end
  endtask

  function automatic int fetch_diff();
    if (got_fetch.size() != exp_fetch.size()) return -2;
    foreach (exp_fetch[i]) if (got_fetch[i] !== exp_fetch[i]) return i;
    return -1;
  endfunction

  function automatic int issue_diff();
    if (got_issue.size() != exp_issue.size()) return -2;
    foreach (exp_issue[i]) if (got_issue[i] !== exp_issue[i]) return i;
    return -1;
  endfunction

  // rmode 0: ready always high, 1: random ready. poke: pulse start (ignored) during ISSUE.
  task automatic run(input logic [11:0] a, input int rmode, input bit poke);
    bit poked = 0;
    got_fetch.delete(); got_issue.delete();
    ill_cnt = 0; stab_err = 0;
    first_fetch_rel = -1; first_valid_rel = -1; halted_rel = -1;
    timed_out = 1;
    mon_en = 1;
    @(posedge clk); #1;
    start = 1; start_addr = a; start_cyc = cyc;
    inst_ready = (rmode == 0) ? 1'b1 : 1'($urandom % 2);
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      start = 0;
      if (halted) begin
        halted_rel = cyc - start_cyc;
        timed_out = 0;
        break;
      end
      if (inst_valid && rpat.size() > 0) inst_ready = rpat.pop_front();
      else inst_ready = (rmode == 0) ? 1'b1 : 1'($urandom % 2);
      if (poke && inst_valid && !poked) begin
        start = 1; start_addr = 12'h300; poked = 1;
      end
    end
    @(negedge clk);
    mon_en = 0;
    start = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({imem_rd_en, imem_addr, inst_valid, inst_data, busy, halted, illegal_op} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got rd=%b addr=%h v=%b d=%h busy=%b halt=%b ill=%b want all 0",
               imem_rd_en, imem_addr, inst_valid, inst_data, busy, halted, illegal_op);
    end
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({imem_rd_en, busy, halted, inst_valid} !== 4'b0) begin
      bad++;
      $display("FAIL idle_after_reset got rd=%b busy=%b halt=%b v=%b want 0", imem_rd_en, busy, halted, inst_valid);
    end
  endtask

  task automatic test_basic();
    clear_mem();
    mem[12'h010] = 32'h1001_0020;
    model(12'h010);
    run(12'h010, 0, 0);
    total++;
    if (first_fetch_rel != 1) begin bad++; $display("FAIL basic_fetch_cycle got %0d want 1", first_fetch_rel); end
    total++;
    if (first_valid_rel != 3) begin bad++; $display("FAIL basic_valid_cycle got %0d want 3", first_valid_rel); end
    total++;
    if (timed_out || halted_rel != 6) begin bad++; $display("FAIL basic_halt_cycle got %0d want 6", halted_rel); end
    total++;
    if (got_issue.size() != 1 || got_issue[0] !== 32'h1001_0020)
      begin bad++; $display("FAIL basic_issue got n=%0d want one 10010020", got_issue.size()); end
    total++;
    if (fetch_diff() != -1) begin bad++; $display("FAIL basic_fetch_order got diff=%0d want -1", fetch_diff()); end
  endtask

  task automatic test_repeat();
    clear_mem();
    mem[12'h060] = 32'hA000_0004;
    mem[12'h061] = 32'h6123_4567;
    model(12'h060);
    rpat = '{1, 0, 1, 1, 0, 1};
    run(12'h060, 0, 0);
    total++;
    if (issue_diff() != -1) begin bad++; $display("FAIL repeat4_issues got n=%0d want 4", got_issue.size()); end
    total++;
    if (stab_err != 0) begin bad++; $display("FAIL repeat4_stable got %0d unstable stalls want 0", stab_err); end
    total++;
    if (fetch_diff() != -1 || timed_out) begin bad++; $display("FAIL repeat4_fetch got diff=%0d want -1", fetch_diff()); end
    clear_mem();
    mem[12'h070] = 32'hA555_0000;
    mem[12'h071] = 32'h2000_0001;
    model(12'h070);
    run(12'h070, 0, 0);
    total++;
    if (issue_diff() != -1) begin bad++; $display("FAIL repeat0_issues got n=%0d want %0d", got_issue.size(), exp_issue.size()); end
  endtask

  task automatic test_jump_wrap();
    clear_mem();
    mem[12'h005] = 32'hB123_4FFF;
    mem[12'hFFF] = 32'h0000_0000;
    mem[12'h000] = W_HALT;
    model(12'h005);
    run(12'h005, 0, 0);
    total++;
    if (fetch_diff() != -1) begin
      bad++;
      $display("FAIL jump_wrap_fetch got n=%0d first=%h want 005,fff,000", got_fetch.size(),
               got_fetch.size() > 0 ? got_fetch[0] : 32'hX);
    end
    total++;
    if (first_valid_rel != -1 || timed_out) begin bad++; $display("FAIL jump_wrap_no_issue got valid_rel=%0d halt_to=%b want -1,0", first_valid_rel, timed_out); end
  endtask

  task automatic test_arm();
    clear_mem();
    mem[12'h080] = 32'hA000_0003;
    mem[12'h081] = 32'h0000_0000;
    mem[12'h082] = 32'hB000_0090;
    mem[12'h090] = 32'h4000_00AA;
    mem[12'h091] = 32'hA000_0002;
    mem[12'h092] = 32'hA000_0005;
    mem[12'h093] = 32'h8000_00BB;
    mem[12'h094] = 32'hA000_0003;
    mem[12'h095] = 32'h0000_0000;
    mem[12'h096] = 32'h1000_00CC;
    model(12'h080);
    run(12'h080, 1, 0);
    total++;
    if (issue_diff() != -1) begin bad++; $display("FAIL arm_issues got n=%0d want %0d diff=%0d", got_issue.size(), exp_issue.size(), issue_diff()); end
    total++;
    if (fetch_diff() != -1 || timed_out) begin bad++; $display("FAIL arm_fetch got diff=%0d want -1", fetch_diff()); end
  endtask

  task automatic test_illegal();
    clear_mem();
    mem[12'h020] = 32'hE000_0000;
    mem[12'h021] = 32'h3000_0033;
    model(12'h020);
    run(12'h020, 1, 1);
    total++;
    if (ill_cnt != 1) begin bad++; $display("FAIL illegal_pulse got %0d cycles want 1", ill_cnt); end
    total++;
    if (fetch_diff() != -1 || timed_out) begin bad++; $display("FAIL illegal_fetch_order got diff=%0d want -1", fetch_diff()); end
    total++;
    if (issue_diff() != -1) begin bad++; $display("FAIL illegal_issue got n=%0d want 1", got_issue.size()); end
  endtask

  task automatic test_rst_mid_issue();
    bit seen = 0;
    clear_mem();
    mem[12'h040] = 32'hA000_0003;
    mem[12'h041] = 32'h3000_0ABC;
    @(posedge clk); #1;
    inst_ready = 0; start = 1; start_addr = 12'h040;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      start = 0;
      seen = inst_valid;
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (!seen || inst_valid !== 1'b1 || inst_data !== 32'h3000_0ABC)
      begin bad++; $display("FAIL stall_hold got v=%b d=%h want 1 30000abc", inst_valid, inst_data); end
    #2 rst = 1;
    #1;
    total++;
    if ({imem_rd_en, imem_addr, inst_valid, inst_data, busy, halted, illegal_op} !== '0)
      begin bad++; $display("FAIL async_reset got v=%b d=%h busy=%b addr=%h want 0", inst_valid, inst_data, busy, imem_addr); end
    @(posedge clk); #1;
    rst = 0;
    clear_mem();
    mem[12'h050] = 32'h5000_0001;
    model(12'h050);
    run(12'h050, 0, 0);
    total++;
    if (issue_diff() != -1 || fetch_diff() != -1 || timed_out)
      begin bad++; $display("FAIL restart got issues=%0d fetches=%0d want 1,2", got_issue.size(), got_fetch.size()); end
  endtask

  task automatic test_random();
    for (int p = 0; p < 10; p++) begin
      int base, n, kind;
      logic [31:0] w;
      clear_mem();
      base = $urandom_range(16'h100, 16'hE00);
      n = $urandom_range(6, 16);
      for (int i = 0; i < n; i++) begin
        kind = $urandom_range(0, 4);
        w = $urandom;
        case (kind)
          0: w = 32'h0;
          1: w = {4'($urandom_range(1, 8)), w[27:0]};
          2: w = {4'hA, w[27:16], 16'($urandom_range(0, 4))};
          3: w = {4'($urandom_range(12, 15)), w[27:0]};
          default: w = {4'hB, w[27:12], 12'(base + i + 1 + $urandom_range(0, 2))};
        endcase
        if (kind == 4 && w[11:0] > 12'(base + n)) w[11:0] = 12'(base + n);
        mem[base + i] = w;
      end
      model(12'(base));
      run(12'(base), 1, 0);
      total++;
      if (issue_diff() != -1) begin bad++; $display("FAIL rand%0d_issue got n=%0d want %0d diff=%0d", p, got_issue.size(), exp_issue.size(), issue_diff()); end
      total++;
      if (fetch_diff() != -1 || timed_out) begin bad++; $display("FAIL rand%0d_fetch got diff=%0d to=%b want -1,0", p, fetch_diff(), timed_out); end
      total++;
      if (ill_cnt != exp_ill || stab_err != 0) begin bad++; $display("FAIL rand%0d_ill_stab got ill=%0d stab=%0d want %0d,0", p, ill_cnt, stab_err, exp_ill); end
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_basic();
    test_repeat();
    test_jump_wrap();
    test_arm();
    test_illegal();
    test_rst_mid_issue();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
